tt_um_logic_unit: RTL and testbench
===================================

# tt_um_logic_unit

Parametrised, pipelined bitwise logic unit. It is the next generation of the team's fixed 8-bit AND tile and sits behind the `tt_um_*` top wrapper in the same place. Operands are captured under a valid strobe. One of four bitwise operations is applied, optionally against an internal accumulator instead of operand `a`. The result, a zero flag and an optional population count are delivered after a configurable number of register stages. The wrapper's `ena` stalls the whole pipeline.

## Interface
- `WIDTH`, default 8: operand and result width, range 2..32.
- `STAGES`, default 2: total latency in clock cycles, range 1..4.
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: synchronous reset, active-high. Clears all state on the clock edge where it is sampled high.
- `ena`  in  1: pipeline advance enable. When low, all registers hold, including the accumulator and the valid bits.
- `in_valid`  in  1: the operands and controls are a transaction this cycle.
- `op`  in  2: operation select. 00 AND, 01 OR, 10 XOR, 11 NAND.
- `acc_en`  in  1: replace operand `a` with the accumulator register.
- `acc_clr`  in  1: clear the accumulator.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `out_valid`  out  1: `y`, `zero` and `count` carry a result.
- `y`  out  WIDTH: result.
- `zero`  out  1: high when `y` == 0. Meaningful only when `out_valid` is high.
- `count`  out  $clog2(WIDTH+1): number of 1 bits in `y`.

## Operation
- **Stage 1 (compute):** on an edge where `ena`=1 and `in_valid`=1, the unit registers `r1 = f(op, A', b)`, with `A' = acc_en ? acc : a`.
  - NAND is `~(A' & b)`, full WIDTH.
  - All operations are bitwise, with no carries and no width growth.
- **Accumulator:** WIDTH bits.
  - On a captured transaction, `acc <= r1_next`, i.e. every result updates `acc`, whatever the value of `acc_en`.
  - `acc_clr`=1 with `ena`=1 sets `acc` to 0. That cycle's `in_valid` is ignored: no transaction is issued and `acc` is not updated by it.
- **Later stages:** stages 2..STAGES are plain delay registers for the data and valid bits.
  - `zero` and `count` are computed from the stage-(STAGES-1) data and registered in the final stage alongside `y`.
  - With `STAGES`=1, they are computed from `r1_next`.
- **Valid pipeline:** a valid bit travels with each stage.
  - When the valid bit is 0, the data registers may hold stale values.
  - `y`, `zero` and `count` nevertheless hold their last values; they are not forced to 0.
- **Stall:** `ena`=0 freezes every register. Inputs in that cycle are ignored. No transaction is lost or duplicated across a stall.
- **Reset:** clears the valid bits, all data registers and `acc` to 0.
  - It overrides `ena`, `in_valid` and `acc_clr`.
  - Transactions in flight are discarded.

## Timing
- **Latency:** a transaction captured at edge N (`ena` high on every edge from N onward) appears with `out_valid`=1 in the cycle after edge N+STAGES-1, i.e. STAGES edges after it is presented.
- **Throughput:** one transaction per cycle. There is no backpressure other than `ena`.
- **Back-to-back accumulator use:** a transaction at edge N+1 with `acc_en` sees the result from edge N, with no bubble.
- **Reset values:**
  - `out_valid`=0, `y`=0, `zero`=0, `count`=0, `acc`=0.
  - The first output is possible STAGES edges after the first edge at which `reset` is low.

## Configuration
- Macro `LOGIC_UNIT_POPCNT_EN`.
- **Defined:** the `count` logic and its pipeline register are built and behave as specified above.
- **Undefined:** the `count` port remains, tied to constant 0. No popcount logic is built. All other behaviour is identical.

## Test plan
Unless noted, `WIDTH`=8 and `STAGES`=2.
- **Reset:** hold `reset` 2 cycles with `in_valid`=1, `a`=0xFF, `b`=0xFF → `out_valid`=0, `y`=0x00, `zero`=0, `count`=0 during reset and for 2 cycles after release.
- **Op sweep:** `a`=0xF0, `b`=0x3C, `op`=00,01,10,11 on 4 consecutive cycles → `y`=0x30, 0xFC, 0xCC, 0xCF on 4 consecutive cycles, starting 2 cycles later, with `out_valid` high throughout.
- **Accumulate:**
  - `acc_clr` for 1 cycle, then `acc_en`=1, `op`=OR, `b`=0x01, 0x02, 0x04 back-to-back → `y`=0x01, 0x03, 0x07.
  - Then `acc_clr` together with `in_valid` → no output for that cycle.
- **Stall:** stream 0x11, 0x22, 0x33 (`op`=OR, `b`=0) and drop `ena` for 3 cycles after the second transaction → `y` and `out_valid` frozen during the stall, then 0x33 appears exactly once after `ena` returns.
- **Flags:**
  - `op`=AND, `a`=0xAA, `b`=0x55 → `y`=0x00, `zero`=1.
  - `op`=XOR, `a`=0xFF, `b`=0x0F → `y`=0xF0, `zero`=0, `count`=4 with `LOGIC_UNIT_POPCNT_EN`, `count`=0 without it.
- **Reset mid-flight:** 2 transactions in flight and `acc`=0x07; assert `reset` for 1 cycle → the next cycle shows `out_valid`=0. A following `acc_en` OR with `b`=0x80 yields 0x80. Repeat the case with `STAGES`=1 and `STAGES`=4.

Source files
------------

// File: rtl/tt_um_logic_unit.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NAND) with accumulator, zero flag
// and optional popcount. Popcount logic is built only when LOGIC_UNIT_POPCNT_EN is defined.
module tt_um_logic_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ena,
    input  logic                         in_valid,
    input  logic [1:0]                   op,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             y,
    output logic                         zero,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] r1_next;
    logic             capture;

    // acc_clr wins over in_valid: a clearing cycle never issues a transaction
    assign capture = in_valid && !acc_clr;
    assign a_sel   = acc_en ? acc : a;

    always_comb begin
        case (op)
            2'b00:   r1_next = a_sel & b;
            2'b01:   r1_next = a_sel | b;
            2'b10:   r1_next = a_sel ^ b;
            default: r1_next = ~(a_sel & b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (ena) begin
            if (acc_clr)
                acc <= '0;
            else if (in_valid)
                acc <= r1_next;
        end
    end

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][WIDTH-1:0]  data_pipe;

    // Data registers load only with a valid token, so outputs hold their last result
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;
        if (k == 1) begin : g_first
            assign v_in = capture;
            assign d_in = r1_next;
        end else begin : g_next
            assign v_in = vld_pipe[k-1];
            assign d_in = data_pipe[k-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_pipe[k]  <= 1'b0;
                data_pipe[k] <= '0;
            end else if (ena) begin
                vld_pipe[k] <= v_in;
                if (v_in)
                    data_pipe[k] <= d_in;
            end
        end
    end

    logic             last_v;
    logic [WIDTH-1:0] last_d;

    if (STAGES == 1) begin : g_last1
        assign last_v = capture;
        assign last_d = r1_next;
    end else begin : g_lastn
        assign last_v = vld_pipe[STAGES-1];
        assign last_d = data_pipe[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset)
            zero <= 1'b0;
        else if (ena && last_v)
            zero <= (last_d == '0);
    end

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int CW = $clog2(WIDTH+1);
    logic [CW-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + CW'(last_d[i]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (ena && last_v)
            count <= pop;
    end
`else
    assign count = '0;
`endif

    assign out_valid = vld_pipe[STAGES];
    assign y         = data_pipe[STAGES];

endmodule

// File: tb/tb_tt_um_logic_unit.sv
// Bench for tt_um_logic_unit: three instances (STAGES 2, 1, 4) share stimulus and
// are checked against one scoreboard queue with a read pointer per instance.
module tb_tt_um_logic_unit;

    logic       clk;
    logic       reset, ena, in_valid, acc_en, acc_clr;
    logic [1:0] op;
    logic [7:0] a, b;

    logic       ov [3];
    logic [7:0] yy [3];
    logic       zz [3];
    logic [3:0] cc [3];

    tt_um_logic_unit #(.WIDTH(8), .STAGES(2)) u_s2 (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .op(op),
        .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(ov[0]), .y(yy[0]), .zero(zz[0]), .count(cc[0]));
    tt_um_logic_unit #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .op(op),
        .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(ov[1]), .y(yy[1]), .zero(zz[1]), .count(cc[1]));
    tt_um_logic_unit #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .op(op),
        .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(ov[2]), .y(yy[2]), .zero(zz[2]), .count(cc[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] y;
        int         t;
    } exp_t;

    exp_t       hist [$];
    int         stg  [3] = '{2, 1, 4};
    int         rp   [3];
    logic       ev   [3];
    logic [7:0] ey   [3];
    logic       ez   [3];
    logic [3:0] ec   [3];
    logic [7:0] acc_m;
    int         tick;
    bit         started;
    int         vectors;
    int         miscompares;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s dut%0d(STAGES=%0d) t=%0t: observed %0h expected %0h",
                   tag, i, stg[i], $time, obs, expv);
        end
    endtask

    // Reference behaviour for the edge about to happen, from the inputs now applied
    task automatic model_step();
        logic [7:0] av, r;
        if (reset) begin
            acc_m   = 8'h00;
            started = 1'b1;
            for (int i = 0; i < 3; i++) begin
                rp[i] = hist.size();
                ev[i] = 1'b0; ey[i] = 8'h00; ez[i] = 1'b0; ec[i] = 4'd0;
            end
        end else if (ena) begin
            tick++;
            if (acc_clr)
                acc_m = 8'h00;
            else if (in_valid) begin
                av = acc_en ? acc_m : a;
                case (op)
                    2'b00:   r = av & b;
                    2'b01:   r = av | b;
                    2'b10:   r = av ^ b;
                    default: r = ~(av & b);
                endcase
                acc_m = r;
                hist.push_back('{r, tick});
            end
            for (int i = 0; i < 3; i++) begin
                if (rp[i] < hist.size() && hist[rp[i]].t + stg[i] - 1 == tick) begin
                    ev[i] = 1'b1;
                    ey[i] = hist[rp[i]].y;
                    ez[i] = (ey[i] == 8'h00);
`ifdef LOGIC_UNIT_POPCNT_EN
                    ec[i] = 4'($countones(ey[i]));
`else
                    ec[i] = 4'd0;
`endif
                    rp[i]++;
                end else
                    ev[i] = 1'b0;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
            if (started)
                for (int i = 0; i < 3; i++) begin
                    chk("out_valid", i, 32'(ov[i]), 32'(ev[i]));
                    chk("y",         i, 32'(yy[i]), 32'(ey[i]));
                    chk("zero",      i, 32'(zz[i]), 32'(ez[i]));
                    chk("count",     i, 32'(cc[i]), 32'(ec[i]));
                end
        end
    endtask

    task automatic drv(input logic iv, input logic [1:0] o, input logic ae, input logic ac,
                       input logic [7:0] aa, input logic [7:0] bb);
        in_valid = iv; op = o; acc_en = ae; acc_clr = ac; a = aa; b = bb;
        cyc(1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; tick = 0; started = 1'b0; acc_m = 8'h00;
        for (int i = 0; i < 3; i++) begin
            rp[i] = 0; ev[i] = 1'b0; ey[i] = 8'h00; ez[i] = 1'b0; ec[i] = 4'd0;
        end
        reset = 1'b1; ena = 1'b1;
        in_valid = 1'b1; op = 2'b00; acc_en = 1'b0; acc_clr = 1'b0; a = 8'hFF; b = 8'hFF;

        // reset held with a live transaction on the inputs
        cyc(2);
        reset = 1'b0;
        drv(0, 2'b00, 0, 0, 8'h00, 8'h00);
        drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        // op sweep: 0x30, 0xFC, 0xCC, 0xCF
        for (int k = 0; k < 4; k++) drv(1, 2'(k), 0, 0, 8'hF0, 8'h3C);
        for (int k = 0; k < 4; k++) drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        // accumulate 0x01, 0x03, 0x07, then clear with in_valid set
        drv(0, 2'b00, 0, 1, 8'h00, 8'h00);
        drv(1, 2'b01, 1, 0, 8'h00, 8'h01);
        drv(1, 2'b01, 1, 0, 8'h00, 8'h02);
        drv(1, 2'b01, 1, 0, 8'h00, 8'h04);
        drv(1, 2'b01, 0, 1, 8'h5A, 8'hA5);
        for (int k = 0; k < 5; k++) drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        // stall after the second transaction; inputs during the stall are ignored
        drv(1, 2'b01, 0, 0, 8'h11, 8'h00);
        drv(1, 2'b01, 0, 0, 8'h22, 8'h00);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) drv(1, 2'b01, 0, 0, 8'h99, 8'h00);
        ena = 1'b1;
        drv(1, 2'b01, 0, 0, 8'h33, 8'h00);
        for (int k = 0; k < 5; k++) drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        // flags
        drv(1, 2'b00, 0, 0, 8'hAA, 8'h55);
        drv(1, 2'b10, 0, 0, 8'hFF, 8'h0F);
        for (int k = 0; k < 5; k++) drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        // reset with transactions in flight and acc = 0x07
        drv(0, 2'b00, 0, 1, 8'h00, 8'h00);
        drv(1, 2'b01, 1, 0, 8'h00, 8'h01);
        drv(1, 2'b01, 1, 0, 8'h00, 8'h02);
        drv(1, 2'b01, 1, 0, 8'h00, 8'h04);
        reset = 1'b1;
        drv(1, 2'b01, 1, 0, 8'h00, 8'hFF);
        reset = 1'b0;
        drv(1, 2'b01, 1, 0, 8'h00, 8'h80);
        for (int k = 0; k < 5; k++) drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        // random traffic with stalls, clears and occasional reset
        for (int k = 0; k < 200; k++) begin
            reset = ($urandom_range(0, 60) == 0);
            ena   = ($urandom_range(0, 4) != 0);
            drv(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom));
        end
        reset = 1'b0; ena = 1'b1;
        for (int k = 0; k < 6; k++) drv(0, 2'b00, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < 3; i++) chk("drain", i, 32'(rp[i]), 32'(hist.size()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
